mem_interface_unit: RTL and testbench
=====================================

Name: mem_interface_unit

Overview:
- Sits between the Mini-SRC datapath/control unit and the 512x32 synchronous-read main memory.
- Owns the MAR and MDR.
- Sequences read/write transactions over a req/done handshake and absorbs the memory's one-cycle registered-address read latency.
- Presents the captured MDR value to the CPU bus; flags out-of-range addresses.

Parameters:
- DATA_W, 32, data/bus width
- ADDR_W, 9, memory word-address width (512 words)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  transaction request, sampled only in IDLE
- rw  in  1  0=read, 1=write; qualified by req
- addr_in  in  DATA_W  effective address from bus
- wdata_in  in  DATA_W  store data from bus
- mdr_load  in  1  load MDR directly from mdr_bus_in (no memory access)
- mdr_bus_in  in  DATA_W  bus value for mdr_load
- ram_data_from_ram  in  DATA_W  memory read data; valid the cycle after the address edge
- ram_address  out  ADDR_W  memory address = MAR
- ram_read  out  1  read strobe
- ram_write  out  1  write strobe
- ram_data_to_ram  out  DATA_W  memory write data = MDR
- mdr_out  out  DATA_W  MDR contents to bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse with done when the address is out of range

Behaviour:
- Reset (async) values:
  - state=IDLE, MAR=0, MDR=0.
  - ram_read=0, ram_write=0, busy=0, done=0, fault=0.
  - ram_address=0, mdr_out=0.
- FSM states: IDLE, RD_ISSUE, RD_CAPTURE, WR, DONE, FAULT.
- IDLE, req=1, addr_in[DATA_W-1:ADDR_W] != 0:
  - next state FAULT; MAR and MDR unchanged; no memory strobe.
- IDLE, req=1, rw=0, address in range:
  - MAR <= addr_in[ADDR_W-1:0]; next state RD_ISSUE.
- IDLE, req=1, rw=1, address in range:
  - MAR <= addr_in[ADDR_W-1:0]; MDR <= wdata_in; next state WR.
- IDLE, req=0, mdr_load=1:
  - MDR <= mdr_bus_in; stay IDLE; done is not pulsed.
- RD_ISSUE:
  - ram_read=1; ram_address=MAR (memory registers it at this edge).
  - Next state RD_CAPTURE.
- RD_CAPTURE:
  - MDR <= ram_data_from_ram at the end of the cycle; next state DONE.
- WR:
  - ram_write=1, ram_address=MAR, ram_data_to_ram=MDR.
  - Memory commits at the end of the cycle; next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE.
- FAULT: done=1 and fault=1 for one cycle; next state IDLE.
- Latency, counted in rising edges from the req-sampling edge to the done cycle:
  - read: done asserted after 3 edges, with mdr_out already valid in the done cycle.
  - write: done asserted after 2 edges.
  - fault: done asserted after 1 edge.
- Handshake:
  - req and mdr_load are ignored whenever busy=1; nothing is queued.
  - The requester must keep req low or re-present it after done; a new req may be accepted in the cycle after DONE.
- Simultaneous req and mdr_load in IDLE: req wins; mdr_load is dropped.
- ram_read and ram_write are never high together; both are decoded from state (Moore), so they are glitch-free with respect to inputs.
- Outside RD_ISSUE and WR, ram_address holds MAR and ram_data_to_ram holds MDR.
- Reset mid-operation:
  - Asserting reset in WR forces ram_write low immediately (async), so the pending write does not commit at the next edge.
  - Asserting reset during a read discards it; MDR=0.
- mdr_out always equals MDR; it changes only on the load/capture edges defined above.

Decomposition:
- Package mini_src_mem_pkg holds:
  - DATA_W and ADDR_W constants.
  - The FSM state enumeration.
  - MEM_WORDS=512.
- One sub-module, mdr_reg: the MDR register with a three-way input select (hold / mdr_bus_in or wdata_in / ram_data_from_ram), async reset, and a load enable.
- MAR and the FSM stay in the top module.

Test Plan:
- Read: memory preloaded with word 0x95 = 0x00000022; req=1, rw=0, addr_in=0x00000095.
  - Required: ram_read high for exactly 1 cycle; done high 3 edges later; mdr_out=0x00000022; fault=0.
- Write then read back: write addr_in=0x87, wdata_in=0xDEADBEEF, then read 0x87.
  - Required: ram_write high exactly 1 cycle with ram_address=0x087; done after 2 edges; the read returns 0xDEADBEEF.
- Out of range: req=1, rw=1, addr_in=0x00000200.
  - Required: fault=1 and done=1 one edge later; ram_write never asserted; MAR and MDR unchanged.
- Busy / collision:
  - req held high throughout a read: exactly one transaction completes before IDLE; the next req is accepted only after done.
  - req and mdr_load=1 (mdr_bus_in=0x12345678) together in IDLE: MDR is not loaded with 0x12345678.
  - mdr_load alone in IDLE: mdr_out=0x12345678 after one edge; done stays 0.
- Reset mid-write: assert reset while in WR.
  - Required: ram_write falls before the next edge; a subsequent read of that address returns its old value; all outputs are at their reset values.

Source files
------------

// File: rtl/mem_interface_unit_pkg.sv
// Shared constants and types for the Mini-SRC memory interface unit.
package mini_src_mem_pkg;

    localparam int MEM_WORDS = 512;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ISSUE   = 3'd1,
        ST_RD_CAPTURE = 3'd2,
        ST_WR         = 3'd3,
        ST_DONE       = 3'd4,
        ST_FAULT      = 3'd5
    } mem_state_e;

    typedef enum logic [1:0] {
        MDR_SRC_HOLD = 2'd0,
        MDR_SRC_BUS  = 2'd1,
        MDR_SRC_RAM  = 2'd2
    } mdr_src_e;

    // An effective address is legal only if no bits above the word address are set.
    function automatic logic addr_in_range(input logic [DATA_W-1:0] addr);
        return (addr[DATA_W-1:ADDR_W] == {(DATA_W-ADDR_W){1'b0}});
    endfunction

endpackage

// File: rtl/mem_interface_unit_if.sv
// CPU-side handshake and memory-side bus of the memory interface unit.
interface mem_interface_unit_if;
    import mini_src_mem_pkg::*;

    logic              req;
    logic              rw;
    logic [DATA_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              mdr_load;
    logic [DATA_W-1:0] mdr_bus_in;
    logic [DATA_W-1:0] ram_data_from_ram;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] ram_data_to_ram;
    logic [DATA_W-1:0] mdr_out;
    logic              busy;
    logic              done;
    logic              fault;

    modport slave (
        input  req, rw, addr_in, wdata_in, mdr_load, mdr_bus_in, ram_data_from_ram,
        output ram_address, ram_read, ram_write, ram_data_to_ram, mdr_out, busy, done, fault
    );

    modport master (
        output req, rw, addr_in, wdata_in, mdr_load, mdr_bus_in, ram_data_from_ram,
        input  ram_address, ram_read, ram_write, ram_data_to_ram, mdr_out, busy, done, fault
    );

endinterface

// File: rtl/mem_interface_unit_mdr_reg.sv
// Memory data register: holds, loads from the CPU bus, or captures memory read data.
module mdr_reg
    import mini_src_mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  mdr_src_e          src,
    input  logic [DATA_W-1:0] bus_data,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] d_s;

    // Select the next MDR value.
    always_comb begin
        d_s = q_r;
        case (src)
            MDR_SRC_BUS:  d_s = bus_data;
            MDR_SRC_RAM:  d_s = ram_data;
            MDR_SRC_HOLD: d_s = q_r;
            default:      d_s = q_r;
        endcase
    end

    // MDR storage with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r <= {DATA_W{1'b0}};
        end else if (load_en) begin
            q_r <= d_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/mem_interface_unit.sv
// Mini-SRC memory interface unit: owns MAR/MDR and sequences reads/writes to
// the 512x32 synchronous-read memory over a req/done handshake.
module mem_interface_unit
    import mini_src_mem_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    mem_interface_unit_if.slave  bus
);

    mem_state_e        state_r;
    mem_state_e        next_state_s;
    logic [ADDR_W-1:0] mar_r;
    logic              mar_load_s;
    mdr_src_e          mdr_src_s;
    logic              mdr_load_en_s;
    logic [DATA_W-1:0] mdr_bus_data_s;
    logic [DATA_W-1:0] mdr_s;
    logic              ram_read_s;
    logic              ram_write_s;
    logic              done_s;
    logic              fault_s;

    // State register; reset drops any in-flight transaction at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state plus MAR/MDR load controls; requests are only looked at in IDLE.
    always_comb begin
        next_state_s   = state_r;
        mar_load_s     = 1'b0;
        mdr_src_s      = MDR_SRC_HOLD;
        mdr_bus_data_s = bus.mdr_bus_in;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    if (!addr_in_range(bus.addr_in)) begin
                        next_state_s = ST_FAULT;
                    end else if (bus.rw) begin
                        next_state_s   = ST_WR;
                        mar_load_s     = 1'b1;
                        mdr_src_s      = MDR_SRC_BUS;
                        mdr_bus_data_s = bus.wdata_in;
                    end else begin
                        next_state_s = ST_RD_ISSUE;
                        mar_load_s   = 1'b1;
                    end
                end else if (bus.mdr_load) begin
                    mdr_src_s = MDR_SRC_BUS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD_ISSUE:   next_state_s = ST_RD_CAPTURE;
            ST_RD_CAPTURE: begin
                next_state_s = ST_DONE;
                mdr_src_s    = MDR_SRC_RAM;
            end
            ST_WR:         next_state_s = ST_DONE;
            ST_DONE:       next_state_s = ST_IDLE;
            ST_FAULT:      next_state_s = ST_IDLE;
            default:       next_state_s = ST_IDLE;
        endcase
    end

    assign mdr_load_en_s = (mdr_src_s != MDR_SRC_HOLD);

    // Memory address register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mar_r <= {ADDR_W{1'b0}};
        end else if (mar_load_s) begin
            mar_r <= bus.addr_in[ADDR_W-1:0];
        end else begin
            mar_r <= mar_r;
        end
    end

    mdr_reg u_mdr_reg (
        .clock    (clock),
        .reset    (reset),
        .load_en  (mdr_load_en_s),
        .src      (mdr_src_s),
        .bus_data (mdr_bus_data_s),
        .ram_data (bus.ram_data_from_ram),
        .q        (mdr_s)
    );

    // Strobes and completion flags are pure functions of the state register.
    always_comb begin
        ram_read_s  = 1'b0;
        ram_write_s = 1'b0;
        done_s      = 1'b0;
        fault_s     = 1'b0;
        case (state_r)
            ST_RD_ISSUE: ram_read_s  = 1'b1;
            ST_WR:       ram_write_s = 1'b1;
            ST_DONE:     done_s      = 1'b1;
            ST_FAULT: begin
                done_s  = 1'b1;
                fault_s = 1'b1;
            end
            default:     ram_read_s  = 1'b0;
        endcase
    end

    assign bus.ram_read        = ram_read_s;
    assign bus.ram_write       = ram_write_s;
    assign bus.done            = done_s;
    assign bus.fault           = fault_s;
    assign bus.busy            = (state_r != ST_IDLE);
    assign bus.ram_address     = mar_r;
    assign bus.ram_data_to_ram = mdr_s;
    assign bus.mdr_out         = mdr_s;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Self-checking bench: transaction-level schedule model plus directed and random stimulus.
module tb_mem_interface_unit;
    import mini_src_mem_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    mem_interface_unit_if bus();

    mem_interface_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Environment memory: synchronous write, registered read address.
    logic [31:0] mem [0:511];
    logic [8:0]  rd_addr_q = 9'd0;
    always @(posedge clock) begin
        if (bus.ram_write) mem[bus.ram_address] = bus.ram_data_to_ram;
        if (bus.ram_read)  rd_addr_q = bus.ram_address;
    end
    assign bus.ram_data_from_ram = mem[rd_addr_q];

    typedef struct packed {
        logic        busy;
        logic        rd;
        logic        wr;
        logic        done;
        logic        fault;
        logic [8:0]  addr;
        logic [31:0] mdr;
    } exp_t;

    exp_t        sched[$];
    logic [31:0] mm [0:511];
    logic [8:0]  mar_m = 9'd0;
    logic [31:0] mdr_m = 32'd0;
    int          n_total = 0;
    int          n_pass = 0;
    bit          chk_en = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [8:0]  wr_addr = 9'd0;

    function automatic exp_t mk(input logic b, input logic r, input logic w, input logic d,
                                input logic f, input logic [8:0] a, input logic [31:0] m);
        exp_t e;
        e = '{busy: b, rd: r, wr: w, done: d, fault: f, addr: a, mdr: m};
        return e;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endfunction

    // Model: on acceptance, lay out the per-cycle outputs the transaction must produce.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sched.delete();
            mar_m <= 9'd0;
            mdr_m <= 32'd0;
        end else if (sched.size() != 0) begin
            if (sched[0].wr) mm[sched[0].addr] = sched[0].mdr;
            void'(sched.pop_front());
        end else if (bus.req) begin
            if (bus.addr_in[31:9] != 23'd0) begin
                sched.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, mar_m, mdr_m));
            end else if (bus.rw) begin
                sched.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, bus.addr_in[8:0], bus.wdata_in));
                sched.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bus.addr_in[8:0], bus.wdata_in));
                mar_m <= bus.addr_in[8:0];
                mdr_m <= bus.wdata_in;
            end else begin
                sched.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, bus.addr_in[8:0], mdr_m));
                sched.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bus.addr_in[8:0], mdr_m));
                sched.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bus.addr_in[8:0], mm[bus.addr_in[8:0]]));
                mar_m <= bus.addr_in[8:0];
                mdr_m <= mm[bus.addr_in[8:0]];
            end
        end else if (bus.mdr_load) begin
            mdr_m <= bus.mdr_bus_in;
        end
    end

    function automatic exp_t cur_exp();
        if (sched.size() != 0) return sched[0];
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mar_m, mdr_m);
    endfunction

    // Per-cycle compare of every output against the model, plus strobe monitors.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("cycle", {18'd0, bus.busy, bus.ram_read, bus.ram_write, bus.done, bus.fault,
                          bus.ram_address, bus.mdr_out}, {18'd0, cur_exp()});
            chk("ram_data_to_ram", {32'd0, bus.ram_data_to_ram}, {32'd0, cur_exp().mdr});
        end
        if (bus.ram_read)  rd_cnt <= rd_cnt + 1;
        if (bus.ram_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.ram_address;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic txn(input logic rw_i, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input bit ld, output int edges);
        bit got;
        got = 1'b0;
        @(negedge clock); #1;
        bus.req = 1'b1; bus.rw = rw_i; bus.addr_in = a; bus.wdata_in = d;
        bus.mdr_load = ld; bus.mdr_bus_in = 32'h12345678;
        @(posedge clock);
        edges = 1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clock);
            if (bus.done) begin
                got = 1'b1;
            end else begin
                #1;
                if (!hold) bus.req = 1'b0;
                @(posedge clock);
                edges++;
            end
        end
        #1;
        bus.req = 1'b0;
        bus.mdr_load = 1'b0;
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    int e;
    int s_rd, s_wr, s_done;

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = $urandom;
            mm[i]  = mem[i];
        end
        mem[9'h095] = 32'h00000022;
        mm[9'h095]  = 32'h00000022;
        bus.req = 1'b0; bus.rw = 1'b0; bus.addr_in = 32'd0; bus.wdata_in = 32'd0;
        bus.mdr_load = 1'b0; bus.mdr_bus_in = 32'd0;

        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_mdr", {32'd0, bus.mdr_out}, 64'd0);
        chk("rst_addr", {55'd0, bus.ram_address}, 64'd0);
        #1 reset = 1'b0;

        // Read of a preloaded word.
        s_rd = rd_cnt;
        txn(1'b0, 32'h00000095, 32'd0, 1'b0, 1'b0, e);
        chk("rd_latency", e, 3);
        chk("rd_data", {32'd0, bus.mdr_out}, {32'd0, 32'h00000022});
        chk("rd_fault", {63'd0, bus.fault}, 64'd0);
        chk("rd_strobe_cycles", rd_cnt - s_rd, 1);

        // Write then read back.
        s_wr = wr_cnt;
        txn(1'b1, 32'h00000087, 32'hDEADBEEF, 1'b0, 1'b0, e);
        chk("wr_latency", e, 2);
        chk("wr_strobe_cycles", wr_cnt - s_wr, 1);
        chk("wr_address", {55'd0, wr_addr}, {55'd0, 9'h087});
        txn(1'b0, 32'h00000087, 32'd0, 1'b0, 1'b0, e);
        chk("wr_readback", {32'd0, bus.mdr_out}, {32'd0, 32'hDEADBEEF});

        // Out-of-range write.
        s_rd = rd_cnt; s_wr = wr_cnt;
        txn(1'b1, 32'h00000200, 32'h55555555, 1'b0, 1'b0, e);
        chk("fault_latency", e, 1);
        chk("fault_flag", {63'd0, bus.fault}, 64'd1);
        chk("fault_no_strobe", (wr_cnt - s_wr) + (rd_cnt - s_rd), 0);
        chk("fault_mdr_kept", {32'd0, bus.mdr_out}, {32'd0, 32'hDEADBEEF});
        chk("fault_mar_kept", {55'd0, bus.ram_address}, {55'd0, 9'h087});

        // req held through a read, with a colliding mdr_load.
        s_done = done_cnt;
        txn(1'b0, 32'h00000095, 32'd0, 1'b1, 1'b1, e);
        chk("hold_latency", e, 3);
        chk("collision_mdr", {32'd0, bus.mdr_out}, {32'd0, 32'h00000022});
        @(negedge clock);
        chk("hold_one_done", done_cnt - s_done, 1);
        chk("hold_idle", {63'd0, bus.busy}, 64'd0);

        // mdr_load alone.
        s_done = done_cnt;
        #1 bus.mdr_load = 1'b1; bus.mdr_bus_in = 32'h12345678;
        @(posedge clock); #1 bus.mdr_load = 1'b0;
        @(negedge clock);
        chk("mdr_load", {32'd0, bus.mdr_out}, {32'd0, 32'h12345678});
        chk("mdr_load_no_done", done_cnt - s_done, 0);

        // Reset in the middle of a write.
        #1 bus.req = 1'b1; bus.rw = 1'b1; bus.addr_in = 32'h00000087; bus.wdata_in = 32'h0BADF00D;
        @(posedge clock);
        @(negedge clock);
        chk("midwr_in_wr", {63'd0, bus.ram_write}, 64'd1);
        #1 reset = 1'b1; bus.req = 1'b0;
        #1;
        chk("midwr_write_low", {63'd0, bus.ram_write}, 64'd0);
        chk("midwr_outputs", {18'd0, bus.busy, bus.ram_read, bus.ram_write, bus.done, bus.fault,
                              bus.ram_address, bus.mdr_out}, 64'd0);
        @(negedge clock); #1 reset = 1'b0;
        txn(1'b0, 32'h00000087, 32'd0, 1'b0, 1'b0, e);
        chk("midwr_old_value", {32'd0, bus.mdr_out}, {32'd0, 32'hDEADBEEF});

        // Randomised traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clock); #1;
            reset          = ($urandom_range(0, 149) == 0);
            bus.req        = ($urandom_range(0, 2) == 0);
            bus.rw         = $urandom_range(0, 1);
            bus.addr_in    = ($urandom_range(0, 7) == 0) ? $urandom : {23'd0, 9'($urandom_range(0, 511))};
            bus.wdata_in   = $urandom;
            bus.mdr_load   = ($urandom_range(0, 3) == 0);
            bus.mdr_bus_in = $urandom;
        end
        @(negedge clock); #1;
        reset = 1'b0; bus.req = 1'b0; bus.mdr_load = 1'b0;
        repeat (6) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
